// File: rtl/lfsr_share_ctrl.sv
// Shares one Fibonacci LFSR among N_REQ requesters with round-robin grants,
// zero-seed protection, optional free-running stepping and step/period tracking.
module lfsr_share_ctrl #(
    parameter int unsigned           WIDTH        = 4,
    parameter logic [WIDTH-1:0]      TAPS         = 4'b1100,
    parameter logic [WIDTH-1:0]      SEED_DEFAULT = 4'b0001,
    parameter int unsigned           N_REQ        = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             free_run_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             rnd_valid_o,
    output logic [WIDTH-1:0] rnd_data_o,
    output logic             seed_err_o,
    output logic [WIDTH-1:0] step_cnt_o,
    output logic             period_done_o
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_LOAD
    } state_e;

    state_e           fsm_q, fsm_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] loaded_q, loaded_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             seed_err_q, seed_err_d;
    logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic             period_q, period_d;

    logic [WIDTH-1:0] lfsr_step;
    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    cand;
    int unsigned      sum;
    int unsigned      ptr_nxt;
    logic             do_step;

    assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

    // Round-robin search starting at the pointer, ascending with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum       = 0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = 32'(ptr_q) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            cand = PW'(sum);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        lfsr_d     = lfsr_q;
        loaded_d   = loaded_q;
        ptr_d      = ptr_q;
        gnt_d      = '0;
        valid_d    = 1'b0;
        data_d     = data_q;
        seed_err_d = 1'b0;
        step_cnt_d = step_cnt_q;
        period_d   = 1'b0;
        do_step    = 1'b0;
        ptr_nxt    = 32'(win_idx) + 1;

        case (fsm_q)
            ST_IDLE:  if (req_i != '0) fsm_d = ST_SERVE;
            ST_SERVE: if (req_i == '0) fsm_d = ST_IDLE;
            ST_LOAD:  fsm_d = (req_i != '0) ? ST_SERVE : ST_IDLE;
            default:  fsm_d = ST_IDLE;
        endcase

        if (seed_load_i) begin
            // A zero seed would lock the LFSR, so substitute the default.
            fsm_d      = ST_LOAD;
            lfsr_d     = (seed_i == '0) ? SEED_DEFAULT : seed_i;
            loaded_d   = (seed_i == '0) ? SEED_DEFAULT : seed_i;
            seed_err_d = (seed_i == '0);
            step_cnt_d = '0;
        end else if (win_found) begin
            if (ptr_nxt >= N_REQ) begin
                ptr_nxt = 0;
            end
            gnt_d[win_idx] = 1'b1;
            valid_d        = 1'b1;
            data_d         = lfsr_q;
            ptr_d          = PW'(ptr_nxt);
            do_step        = 1'b1;
        end else begin
            do_step = free_run_i;
        end

        if (do_step) begin
            lfsr_d     = lfsr_step;
            step_cnt_d = step_cnt_q + WIDTH'(1);
            period_d   = (lfsr_step == loaded_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q      <= ST_IDLE;
            lfsr_q     <= SEED_DEFAULT;
            loaded_q   <= SEED_DEFAULT;
            ptr_q      <= '0;
            gnt_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            seed_err_q <= 1'b0;
            step_cnt_q <= '0;
            period_q   <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            lfsr_q     <= lfsr_d;
            loaded_q   <= loaded_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            seed_err_q <= seed_err_d;
            step_cnt_q <= step_cnt_d;
            period_q   <= period_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign rnd_valid_o   = valid_q;
    assign rnd_data_o    = data_q;
    assign seed_err_o    = seed_err_q;
    assign step_cnt_o    = step_cnt_q;
    assign period_done_o = period_q;

endmodule

// File: doc/lfsr_share_ctrl.md
Name: lfsr_share_ctrl

Overview:
- Controller that owns one Fibonacci LFSR and shares its pseudo-random output among N_REQ requesters using round-robin arbitration.
- Handles seed loading with zero-seed protection, optional free-running stepping, and step/period tracking.
- Sits between the LFSR datapath and the consumers that need random words, such as test-pattern generators and scramblers.

Parameters:
- WIDTH, 4, LFSR state width.
- TAPS, 4'b1100, feedback mask; the default is x^4+x^3+1, which is maximal length with period 15.
- SEED_DEFAULT, 4'b0001, state value on reset and the substitute for an illegal all-zero seed.
- N_REQ, 2, number of requesters (at least 2).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_load  in  1  one-cycle pulse that loads seed into the LFSR.
- seed  in  WIDTH  seed value, sampled when seed_load=1.
- free_run  in  1  when 1, the LFSR advances every cycle whether or not a grant is issued.
- req  in  N_REQ  per-requester request; the requester holds it high until it sees its gnt bit.
- gnt  out  N_REQ  one-hot grant, registered, active for one cycle.
- rnd_valid  out  1  high in the same cycle as any gnt bit.
- rnd_data  out  WIDTH  random word delivered to the granted requester.
- seed_err  out  1  one-cycle pulse: an all-zero seed was rejected.
- step_cnt  out  WIDTH  number of LFSR steps since the last seed or reset, wraps modulo 2^WIDTH.
- period_done  out  1  one-cycle pulse: the LFSR has returned to its loaded seed.

Behaviour:
- LFSR step:
  - fb = XOR-reduce(state & TAPS).
  - next = {state[WIDTH-2:0], fb}.
  - For the default parameters, the sequence from 0001 is 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, then 0001 again.
- Reset (rst=1 at an edge):
  - state=SEED_DEFAULT, loaded_seed=SEED_DEFAULT.
  - gnt=0, rnd_valid=0, rnd_data=0, seed_err=0, step_cnt=0, period_done=0.
  - Round-robin pointer=0, FSM=IDLE.
  - Reset overrides every other input, including in mid-grant; gnt drops on that edge.
- FSM states: IDLE, SERVE, LOAD.
  - seed_load=1 (from any state) -> LOAD.
  - LOAD -> SERVE if req != 0, otherwise IDLE.
  - IDLE -> SERVE when req != 0.
  - SERVE -> IDLE when req == 0.
- LOAD edge (seed_load=1):
  - state <= (seed==0 ? SEED_DEFAULT : seed), and loaded_seed gets the same value.
  - seed_err <= (seed==0).
  - step_cnt <= 0.
  - gnt <= 0, rnd_valid <= 0; no grant is issued and no step is taken on this edge, even if free_run=1.
  - Pending requests remain pending.
- Grant edge (no rst, no seed_load, req != 0):
  - Search req starting at the pointer, ascending with wrap; the first set bit i wins.
  - gnt <= onehot(i), rnd_valid <= 1, rnd_data <= current state.
  - state <= next, step_cnt <= step_cnt+1.
  - Pointer <= (i+1) mod N_REQ.
  - Latency: req sampled at edge k -> gnt/rnd_data visible from edge k until edge k+1.
  - Output rate is at most one grant per cycle.
  - A requester that keeps req high after its grant is treated as making a new request.
- No-request edge:
  - gnt <= 0, rnd_valid <= 0; rnd_data holds its last value.
  - If free_run=1: state <= next and step_cnt increments; otherwise state holds.
- free_run combined with a grant produces exactly one step on that edge, never two.
- period_done <= 1 on any step edge where next == loaded_seed; otherwise 0.
- step_cnt wraps from 2^WIDTH-1 to 0 without a flag.
- A requester dropping req before it is granted withdraws the request; no grant is owed.
- The LFSR state is never all-zero: reset, seed loading and stepping preserve a nonzero state.

Test Plan:
1. Reset, then seed_load with seed=0001 and req=01 held high -> gnt=01 on consecutive cycles, rnd_data=0001, 0010, 0100, 1001; step_cnt=1, 2, 3, 4.
2. req=11 held for 6 cycles after reset -> gnt=01, 10, 01, 10, 01, 10; rnd_data follows the full sequence from 0001 with no repeats and no skips.
3. free_run=1 with no requests for 15 cycles after seed_load 0001 -> period_done pulses exactly on the 15th step, state=0001, step_cnt=15; the 16th step wraps step_cnt to 0.
4. seed_load with seed=0000 -> seed_err pulses for one cycle, state=0001, and the next grant returns rnd_data=0001.
5. seed_load=1 with seed=1010 on the same edge as req=10 -> no gnt on that edge; the next edge gives gnt=10 and rnd_data=1010.
6. rst asserted while req=11 with the pointer at 1 -> gnt=0 on the reset edge; after release the first grant goes to requester 0 with rnd_data=0001.
